// File: rtl/bp_gindex.sv
`default_nettype none
// ============================================================================
// Module   : bp_gindex
// Function : global-history branch direction predictor (global/gselect/gshare)
// Revision : 1.0
// ============================================================================
module bp_gindex #(
  parameter int BP_GLOBAL  = 0,
  parameter int BP_GSELECT = 1,
  parameter int BP_GSHARE  = 2,
  parameter int MODE       = BP_GSHARE,
  parameter int PC_BITS    = 5,
  parameter int GR_BITS    = 9,
  parameter int CNT_BITS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_dec,
  input  logic               spec_enter,
  input  logic               spec_resolve,
  input  logic               spec_wrong,
  input  logic               br_res,
  output logic               pred,
  output logic [GR_BITS-1:0] ghr,
  output logic [31:0]        cnt_br,
  output logic [31:0]        cnt_mispred
);

  localparam int IDX_BITS = (MODE == BP_GLOBAL)  ? GR_BITS :
                            (MODE == BP_GSELECT) ? PC_BITS + GR_BITS :
                            ((PC_BITS > GR_BITS) ? PC_BITS : GR_BITS);
  localparam int c_pht_depth = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] c_cnt_max  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] c_cnt_init = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);

  if (MODE != BP_GLOBAL && MODE != BP_GSELECT && MODE != BP_GSHARE) begin : g_bad_mode
    $error("bp_gindex: MODE must be BP_GLOBAL, BP_GSELECT or BP_GSHARE");
  end
  if (GR_BITS < 1) begin : g_bad_gr
    $error("bp_gindex: GR_BITS must be >= 1");
  end
  if (CNT_BITS < 1 || CNT_BITS > 4) begin : g_bad_cnt
    $error("bp_gindex: CNT_BITS must be in 1..4");
  end

  logic [CNT_BITS-1:0] r_pht [c_pht_depth];
  logic [GR_BITS-1:0]  r_ghr;
  logic [IDX_BITS-1:0] r_idx_exe;
  logic [31:0]         r_cnt_br;
  logic [31:0]         r_cnt_mispred;

  logic [PC_BITS-1:0]  w_pcb;
  logic [IDX_BITS-1:0] w_idx;
  logic [GR_BITS-1:0]  w_ghr_next;
  logic                w_unused_pc;

  assign w_pcb       = pc_dec[PC_BITS+1:2];
  assign w_unused_pc = &{1'b0, pc_dec[31:PC_BITS+2], pc_dec[1:0]};

  if (MODE == BP_GLOBAL) begin : g_global
    logic w_unused_pcb;
    assign w_unused_pcb = ^w_pcb;
    assign w_idx        = r_ghr;
  end else if (MODE == BP_GSELECT) begin : g_gselect
    assign w_idx = {w_pcb, r_ghr};
  end else begin : g_gshare
    // Narrower operand is zero-extended before the XOR fold.
    assign w_idx = IDX_BITS'(w_pcb) ^ IDX_BITS'(r_ghr);
  end

  if (GR_BITS == 1) begin : g_ghr_one
    assign w_ghr_next = br_res;
  end else begin : g_ghr_wide
    assign w_ghr_next = {r_ghr[GR_BITS-2:0], br_res};
  end

  // Prediction reads the pre-update entry; no same-cycle bypass.
  assign pred        = r_pht[w_idx][CNT_BITS-1];
  assign ghr         = r_ghr;
  assign cnt_br      = r_cnt_br;
  assign cnt_mispred = r_cnt_mispred;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_pht_depth; i++) begin
        r_pht[i] <= c_cnt_init;
      end
    end else if (spec_resolve) begin
      if (br_res) begin
        if (r_pht[r_idx_exe] != c_cnt_max) begin
          r_pht[r_idx_exe] <= r_pht[r_idx_exe] + CNT_BITS'(1);
        end
      end else begin
        if (r_pht[r_idx_exe] != '0) begin
          r_pht[r_idx_exe] <= r_pht[r_idx_exe] - CNT_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr         <= '0;
      r_idx_exe     <= '0;
      r_cnt_br      <= '0;
      r_cnt_mispred <= '0;
    end else begin
      if (spec_enter) begin
        r_idx_exe <= w_idx;
      end
      if (spec_resolve) begin
        r_ghr    <= w_ghr_next;
        r_cnt_br <= r_cnt_br + 32'd1;
        if (spec_wrong) begin
          r_cnt_mispred <= r_cnt_mispred + 32'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_gindex.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_gindex
// Function : self-checking bench for bp_gindex (global CNT2, global CNT3, gshare)
// Revision : 1.0
// ============================================================================
module tb_bp_gindex;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_dec = 32'h0;
  logic        spec_enter = 1'b0;
  logic        spec_resolve = 1'b0;
  logic        spec_wrong = 1'b0;
  logic        br_res = 1'b0;

  logic        pred_o [3];
  logic [8:0]  ghr_o  [3];
  logic [31:0] cb_o   [3];
  logic [31:0] cm_o   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_gindex #(.MODE(0), .PC_BITS(5), .GR_BITS(9), .CNT_BITS(2)) d0 (
    .clk(clk), .rst(rst), .pc_dec(pc_dec), .spec_enter(spec_enter),
    .spec_resolve(spec_resolve), .spec_wrong(spec_wrong), .br_res(br_res),
    .pred(pred_o[0]), .ghr(ghr_o[0]), .cnt_br(cb_o[0]), .cnt_mispred(cm_o[0]));
  bp_gindex #(.MODE(0), .PC_BITS(5), .GR_BITS(9), .CNT_BITS(3)) d1 (
    .clk(clk), .rst(rst), .pc_dec(pc_dec), .spec_enter(spec_enter),
    .spec_resolve(spec_resolve), .spec_wrong(spec_wrong), .br_res(br_res),
    .pred(pred_o[1]), .ghr(ghr_o[1]), .cnt_br(cb_o[1]), .cnt_mispred(cm_o[1]));
  bp_gindex #(.MODE(2), .PC_BITS(5), .GR_BITS(9), .CNT_BITS(2)) d2 (
    .clk(clk), .rst(rst), .pc_dec(pc_dec), .spec_enter(spec_enter),
    .spec_resolve(spec_resolve), .spec_wrong(spec_wrong), .br_res(br_res),
    .pred(pred_o[2]), .ghr(ghr_o[2]), .cnt_br(cb_o[2]), .cnt_mispred(cm_o[2]));

  // Reference model: plain integers, history as a number, index by arithmetic.
  int          m_cntb [3] = '{2, 3, 2};
  int          m_pht  [3][512];
  int          m_ghr  [3];
  int          m_idx  [3];
  logic [31:0] m_cb   [3];
  logic [31:0] m_cm   [3];

  function automatic int m_index(input int i, input logic [31:0] pc);
    int pcb;
    pcb = int'((pc / 4) % 32);
    if (i == 2) return m_ghr[i] ^ pcb;
    return m_ghr[i];
  endfunction

  function automatic logic m_pred(input int i, input logic [31:0] pc);
    return (m_pht[i][m_index(i, pc)] >= (1 << (m_cntb[i] - 1)));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      for (int e = 0; e < 512; e++) m_pht[i][e] = (1 << (m_cntb[i] - 1)) - 1;
      m_ghr[i] = 0;
      m_idx[i] = 0;
      m_cb[i]  = 0;
      m_cm[i]  = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        int nidx;
        int top;
        nidx = m_index(i, pc_dec);
        top  = (1 << m_cntb[i]) - 1;
        if (spec_resolve) begin
          if (br_res && m_pht[i][m_idx[i]] < top) m_pht[i][m_idx[i]] += 1;
          if (!br_res && m_pht[i][m_idx[i]] > 0) m_pht[i][m_idx[i]] -= 1;
          m_ghr[i] = (m_ghr[i] * 2 + int'(br_res)) % 512;
          m_cb[i]  = m_cb[i] + 1;
          if (spec_wrong) m_cm[i] = m_cm[i] + 1;
        end
        if (spec_enter) m_idx[i] = nidx;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pred%0d", i), 32'(pred_o[i]), 32'(m_pred(i, pc_dec)));
      chk($sformatf("ghr%0d", i), 32'(ghr_o[i]), 32'(m_ghr[i]));
      chk($sformatf("cnt_br%0d", i), cb_o[i], m_cb[i]);
      chk($sformatf("cnt_mispred%0d", i), cm_o[i], m_cm[i]);
    end
  end

  task automatic chk_pht(input int i);
    int bad;
    bad = 0;
    for (int e = 0; e < 512; e++) begin
      int act;
      case (i)
        0:       act = int'(d0.r_pht[e]);
        1:       act = int'(d1.r_pht[e]);
        default: act = int'(d2.r_pht[e]);
      endcase
      if (act != m_pht[i][e]) bad++;
    end
    chk($sformatf("pht_all%0d_bad_entries", i), 32'(bad), 32'd0);
  endtask

  // Called at posedge+1; inputs held across exactly one active edge.
  task automatic step(input logic e, input logic [31:0] pc, input logic r,
                      input logic w, input logic b);
    spec_enter = e; pc_dec = pc; spec_resolve = r; spec_wrong = w; br_res = b;
    @(posedge clk); #1;
    spec_enter = 1'b0; spec_resolve = 1'b0; spec_wrong = 1'b0; br_res = 1'b0;
  endtask

  task automatic pulse_reset();
    #3 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] hist;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pred%0d", i), 32'(pred_o[i]), 32'd0);
      chk($sformatf("rst_ghr%0d", i), 32'(ghr_o[i]), 32'd0);
    end

    // Always-taken branch at 0x40, enter then resolve, 11 iterations
    for (int k = 1; k <= 11; k++) begin
      step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h40, 1'b1, 1'b0, 1'b1);
      if (k == 9) chk("global_ghr_after9", 32'(ghr_o[0]), 32'h1FF);
    end
    chk("global_pht1ff", 32'(d0.r_pht[9'h1FF]), 32'd3);
    chk("global_pred_after11", 32'(pred_o[0]), 32'd1);
    chk("cnt3_pht1ff_after11", 32'(d1.r_pht[9'h1FF]), 32'd5);

    // Saturation with CNT_BITS=3 on entry 0x1FF
    repeat (10) step(1'b0, 32'h40, 1'b1, 1'b0, 1'b1);
    chk("sat_top", 32'(d1.r_pht[9'h1FF]), 32'd7);
    chk("sat_top_pred", 32'(pred_o[1]), 32'd1);
    step(1'b0, 32'h40, 1'b1, 1'b0, 1'b0);
    chk("sat_dec1", 32'(d1.r_pht[9'h1FF]), 32'd6);
    chk("sat_dec1_msb", 32'(d1.r_pht[9'h1FF][2]), 32'd1);
    repeat (7) step(1'b0, 32'h40, 1'b1, 1'b0, 1'b0);
    chk("sat_bottom", 32'(d1.r_pht[9'h1FF]), 32'd0);
    chk("sat_bottom_pred", 32'(pred_o[1]), 32'd0);
    chk_pht(0);
    chk_pht(1);

    // Reset mid-run with an update in flight, then sweep pc
    spec_resolve = 1'b1; br_res = 1'b1;
    #3 rst = 1'b1;
    #1;
    for (int p = 0; p <= 32'h7C; p += 4) begin
      pc_dec = 32'(p);
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("sweep_pred%0d_pc%0h", i, p), 32'(pred_o[i]), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid_rst_ghr%0d", i), 32'(ghr_o[i]), 32'd0);
      chk($sformatf("mid_rst_cnt_br%0d", i), cb_o[i], 32'd0);
      chk($sformatf("mid_rst_cnt_mispred%0d", i), cm_o[i], 32'd0);
    end
    @(posedge clk); #1;
    spec_resolve = 1'b0; br_res = 1'b0;
    rst = 1'b0;
    chk_pht(1);

    // Gshare index: ghr=0x0A5, pc 0x4C -> idx 0x0B6
    hist = 9'h0A5;
    for (int b = 8; b >= 0; b--) step(1'b0, 32'h4C, 1'b1, 1'b0, hist[b]);
    chk("gshare_ghr", 32'(ghr_o[2]), 32'h0A5);
    step(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0);
    chk("gshare_idx_exe", 32'(d2.r_idx_exe), 32'h0B6);
    step(1'b0, 32'h4C, 1'b1, 1'b0, 1'b1);
    chk("gshare_pht_b6", 32'(d2.r_pht[9'h0B6]), 32'd2);
    chk_pht(2);

    // Simultaneous enter (pc 0x80) and taken resolve of the prior branch
    step(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0);
    chk("simul_prior_idx", 32'(d2.r_idx_exe), 32'h158);
    step(1'b1, 32'h80, 1'b1, 1'b0, 1'b1);
    chk("simul_old_entry", 32'(d2.r_pht[9'h158]), 32'd2);
    chk("simul_new_idx", 32'(d2.r_idx_exe), 32'h14B);
    chk("simul_ghr", 32'(ghr_o[2]), 32'h097);
    chk_pht(2);

    // Statistics
    pulse_reset();
    step(1'b0, 32'h40, 1'b1, 1'b1, 1'b1);
    step(1'b0, 32'h40, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h40, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h40, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h40, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h40, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stat_br%0d", i), cb_o[i], 32'd5);
      chk($sformatf("stat_mispred%0d", i), cm_o[i], 32'd2);
    end
    force d0.r_cnt_br = 32'hFFFF_FFFF;
    m_cb[0] = 32'hFFFF_FFFF;
    #5;
    release d0.r_cnt_br;
    step(1'b0, 32'h40, 1'b1, 1'b0, 1'b1);
    chk("stat_wrap", cb_o[0], 32'd0);
    chk("stat_nowrap_other", cb_o[1], 32'd6);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
